// File: rtl/dds_wave_generator_if.sv
// Key inputs and waveform/index outputs of the DDS wave generator.
//   master: drives W/A/P/F_ctrl keys, observes wave_out, period_start, *_idx
//   slave : the generator core
interface dds_wave_generator_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned A_BITS = 3,
  parameter int unsigned F_BITS = 4,
  parameter int unsigned P_BITS = 3
);
  logic              W_ctrl;
  logic              A_ctrl;
  logic              P_ctrl;
  logic              F_ctrl;
  logic [DATA_W-1:0] wave_out;
  logic              period_start;
  logic [1:0]        W_idx;
  logic [A_BITS-1:0] A_idx;
  logic [F_BITS-1:0] F_idx;
  logic [P_BITS-1:0] P_idx;

  modport master (
    output W_ctrl, A_ctrl, P_ctrl, F_ctrl,
    input  wave_out, period_start, W_idx, A_idx, F_idx, P_idx
  );

  modport slave (
    input  W_ctrl, A_ctrl, P_ctrl, F_ctrl,
    output wave_out, period_start, W_idx, A_idx, F_idx, P_idx
  );
endinterface

// File: rtl/dds_wave_generator.sv
// Direct-digital-synthesis waveform core driven by four push-button keys.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    dds_wave_generator_if.slave
//          W/A/P/F_ctrl : asynchronous active-high keys
//          wave_out     : offset-binary sample
//          period_start : pulse with the first sample of each period
//          W/A/F/P_idx  : current waveform / amplitude / frequency / phase index
module dds_wave_generator #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned FREQ_SHIFT = 10,
  parameter int unsigned F_STEPS    = 16,
  parameter int unsigned A_BITS     = 3,
  parameter int unsigned P_BITS     = 3,
  parameter int unsigned DB_CYC     = 1000000
) (
  input logic                 clk,
  input logic                 rst_n,
  dds_wave_generator_if.slave bus
);

  localparam int unsigned F_BITS = $clog2(F_STEPS);
  localparam int unsigned CNT_W  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int unsigned PW     = DATA_W + A_BITS + 2;
  localparam int unsigned NKEYS  = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYC - 1);
  localparam logic [DATA_W-1:0] MID     = DATA_W'(1) << (DATA_W - 1);
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;
  localparam logic [15:0]       LFSR_TAPS = 16'hB400;

  // Key order in all key vectors: 0 W, 1 A, 2 P, 3 F
  logic [NKEYS-1:0] keys_c;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] db;
  logic [NKEYS-1:0] db_q;
  logic [NKEYS-1:0] press_c;
  logic [CNT_W-1:0] cnt [NKEYS];

  logic [1:0]        w_idx;
  logic [A_BITS-1:0] a_idx;
  logic [F_BITS-1:0] f_idx;
  logic [P_BITS-1:0] p_idx;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  step_c;
  logic [ACC_W:0]    acc_sum_c;
  logic              wrap_q;
  logic              wrap_s1;
  logic              period_q;
  logic [15:0]       lfsr;

  logic [DATA_W-1:0] ph_c;
  logic [DATA_W-1:0] tri_c;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] raw_q;
  logic signed [DATA_W:0]   s_c;
  logic signed [A_BITS+1:0] amp_c;
  logic signed [PW-1:0]     prod_c;
  logic [DATA_W-1:0] wave_c;
  logic [DATA_W-1:0] wave_q;

  assign keys_c  = {bus.F_ctrl, bus.P_ctrl, bus.A_ctrl, bus.W_ctrl};
  assign press_c = db & ~db_q;

  // Synchronisers and per-key debouncers; db flips after DB_CYC disagreeing cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
    end else begin
      sync1 <= keys_c;
      sync2 <= sync1;
      db_q  <= db;
      for (int k = 0; k < NKEYS; k++) begin
        if (sync2[k] != db[k]) begin
          if (cnt[k] == CNT_MAX) begin
            db[k]  <= sync2[k];
            cnt[k] <= '0;
          end else begin
            cnt[k] <= cnt[k] + CNT_W'(1);
          end
        end else begin
          cnt[k] <= '0;
        end
      end
    end
  end

  // Index registers; all ranges are powers of two so wrap is natural overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_idx <= '0;
      a_idx <= '1;
      f_idx <= '0;
      p_idx <= '0;
    end else begin
      w_idx <= w_idx + 2'(press_c[0]);
      a_idx <= a_idx + A_BITS'(press_c[1]);
      p_idx <= p_idx + P_BITS'(press_c[2]);
      f_idx <= f_idx + F_BITS'(press_c[3]);
    end
  end

  // Phase accumulation and stage-1 raw sample selection
  always_comb begin
    step_c    = (ACC_W'(f_idx) + ACC_W'(1)) << FREQ_SHIFT;
    acc_sum_c = {1'b0, acc} + {1'b0, step_c};
    ph_c      = acc[ACC_W-1 -: DATA_W] + (DATA_W'(p_idx) << (DATA_W - P_BITS));
    tri_c     = ph_c[DATA_W-1] ? ~{ph_c[DATA_W-2:0], 1'b0} : {ph_c[DATA_W-2:0], 1'b0};
    raw_c     = ph_c;
    case (w_idx)
      2'd0:    raw_c = ph_c;
      2'd1:    raw_c = tri_c;
      2'd2:    raw_c = ph_c[DATA_W-1] ? '0 : '1;
      default: raw_c = lfsr[15 -: DATA_W];
    endcase
  end

  // Stage-2 amplitude scaling around mid-scale; product kept at full width
  always_comb begin
    s_c    = $signed({1'b0, raw_q} - {1'b0, MID});
    amp_c  = $signed({1'b0, (A_BITS+1)'(a_idx) + (A_BITS+1)'(1)});
    prod_c = PW'(s_c) * PW'(amp_c);
    wave_c = DATA_W'(prod_c >>> A_BITS) + MID;
  end

  // Datapath registers; the wrap flag rides two extra stages to meet its sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      wrap_q   <= 1'b0;
      wrap_s1  <= 1'b0;
      period_q <= 1'b0;
      lfsr     <= LFSR_SEED;
      raw_q    <= '0;
      wave_q   <= MID;
    end else begin
      acc      <= acc_sum_c[ACC_W-1:0];
      wrap_q   <= acc_sum_c[ACC_W];
      wrap_s1  <= wrap_q;
      period_q <= wrap_s1;
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      raw_q    <= raw_c;
      wave_q   <= wave_c;
    end
  end

  assign bus.wave_out     = wave_q;
  assign bus.period_start = period_q;
  assign bus.W_idx        = w_idx;
  assign bus.A_idx        = a_idx;
  assign bus.F_idx        = f_idx;
  assign bus.P_idx        = p_idx;

endmodule

// File: tb/tb_dds_wave_generator.sv
// Scoreboard bench for dds_wave_generator: a behavioural model predicts each
// output sample two cycles ahead into a queue; a negedge monitor pops and compares.
module tb_dds_wave_generator;

  localparam int DATA_W     = 12;
  localparam int ACC_W      = 16;
  localparam int FREQ_SHIFT = 4;
  localparam int F_STEPS    = 16;
  localparam int A_BITS     = 3;
  localparam int P_BITS     = 3;
  localparam int DB_CYC     = 4;
  localparam int F_BITS     = 4;
  localparam int MID        = 1 << (DATA_W - 1);
  localparam int DMASK      = (1 << DATA_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] wave;
    logic              ps;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] keys;   // 0 W, 1 A, 2 P, 3 F

  dds_wave_generator_if #(.DATA_W(DATA_W), .A_BITS(A_BITS), .F_BITS(F_BITS), .P_BITS(P_BITS)) bus ();

  assign bus.W_ctrl = keys[0];
  assign bus.A_ctrl = keys[1];
  assign bus.P_ctrl = keys[2];
  assign bus.F_ctrl = keys[3];

  dds_wave_generator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .FREQ_SHIFT(FREQ_SHIFT), .F_STEPS(F_STEPS),
    .A_BITS(A_BITS), .P_BITS(P_BITS), .DB_CYC(DB_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  exp_t             expq[$];
  bit               mon_en = 0;
  int               m_acc, m_w, m_a, m_f, m_p;
  logic [15:0]      m_lfsr;
  bit               m_carry;
  bit               pend [4];
  bit               m_db [4];
  bit               sp0 [4];
  bit               sp1 [4];
  logic [DB_CYC-1:0] hist [4];

  function automatic int scale(input int raw, input int a);
    int s;
    s = (raw - MID) * (a + 1);
    return ((s >>> A_BITS) + MID) & DMASK;
  endfunction

  function automatic int raw_sample(input int acc, input int w, input int p, input logic [15:0] lf);
    int ph;
    ph = ((acc >> (ACC_W - DATA_W)) + (p << (DATA_W - P_BITS))) & DMASK;
    case (w)
      0: return ph;
      1: return (ph >= MID) ? DMASK - ((2 * ph) & DMASK) : 2 * ph;
      2: return (ph >= MID) ? 0 : DMASK;
      default: return int'(lf >> (16 - DATA_W));
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   sum;
    bit   obs;
    if (!rst_n) begin
      m_acc = 0; m_w = 0; m_a = (1 << A_BITS) - 1; m_f = 0; m_p = 0;
      m_lfsr = 16'hACE1; m_carry = 0;
      for (int k = 0; k < 4; k++) begin
        pend[k] = 0; m_db[k] = 0; sp0[k] = 0; sp1[k] = 0; hist[k] = '0;
      end
      expq.delete();
      e.wave = DATA_W'(MID); e.ps = 1'b0; expq.push_back(e);
      e.wave = DATA_W'(scale(0, m_a)); e.ps = 1'b0; expq.push_back(e);
      mon_en = 1;
    end else begin
      // sample presented two cycles from now: raw from this cycle, amplitude from next
      e.wave = DATA_W'(scale(raw_sample(m_acc, m_w, m_p, m_lfsr),
                             (m_a + int'(pend[1])) % (1 << A_BITS)));
      e.ps   = m_carry;
      expq.push_back(e);
      sum     = m_acc + ((m_f + 1) << FREQ_SHIFT);
      m_carry = (sum >= (1 << ACC_W));
      m_acc   = sum % (1 << ACC_W);
      m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_w = (m_w + int'(pend[0])) % 4;
      m_a = (m_a + int'(pend[1])) % (1 << A_BITS);
      m_p = (m_p + int'(pend[2])) % (1 << P_BITS);
      m_f = (m_f + int'(pend[3])) % F_STEPS;
      // debounced level flips once the last DB_CYC synchronised samples all disagree
      for (int k = 0; k < 4; k++) begin
        obs     = sp1[k];
        sp1[k]  = sp0[k];
        sp0[k]  = keys[k];
        hist[k] = {hist[k][DB_CYC-2:0], obs};
        pend[k] = 0;
        if (hist[k] == (m_db[k] ? {DB_CYC{1'b0}} : {DB_CYC{1'b1}})) begin
          m_db[k] = ~m_db[k];
          pend[k] = m_db[k];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (expq.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = expq.pop_front();
        chk("wave_out", int'(bus.wave_out), int'(e.wave));
        chk("period_start", int'(bus.period_start), int'(e.ps));
      end
      chk("W_idx", int'(bus.W_idx), m_w);
      chk("A_idx", int'(bus.A_idx), m_a);
      chk("F_idx", int'(bus.F_idx), m_f);
      chk("P_idx", int'(bus.P_idx), m_p);
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input int k, input int len);
    @(negedge clk);
    keys[k] = 1'b1;
    repeat (len) @(negedge clk);
    keys[k] = 1'b0;
    repeat (DB_CYC + 8) @(negedge clk);
  endtask

  int  hold [4];
  int  w1, w2, changes, pulses;
  bit  ok, seen_pk, seen_min;

  initial begin
    rst_n = 1'b0;
    keys  = '0;
    repeat (5) @(negedge clk);
    chk("reset_wave", int'(bus.wave_out), 'h800);
    chk("reset_A_idx", int'(bus.A_idx), 7);
    rst_n = 1'b1;

    // saw at lowest frequency: one wrap per 4096 cycles
    pulses = 0;
    repeat (4200) begin
      @(negedge clk);
      if (bus.period_start) pulses++;
    end
    chk("saw_period_pulses", pulses, 1);

    // debounce: short glitch ignored, long hold counted once
    press(0, 3);
    chk("glitch_W_idx", int'(bus.W_idx), 0);
    press(0, 20);
    chk("hold_W_idx", int'(bus.W_idx), 1);

    // square with reduced amplitude
    press(0, 6);
    press(1, 6);
    ok = 1;
    repeat (64) begin
      @(negedge clk);
      if (!(bus.wave_out == 12'h8FF || bus.wave_out == 12'h700)) ok = 0;
    end
    chk("square_levels_a0", int'(ok), 1);
    press(1, 6);
    ok = 1;
    repeat (64) begin
      @(negedge clk);
      if (!(bus.wave_out == 12'h9FF || bus.wave_out == 12'h600)) ok = 0;
    end
    chk("square_levels_a1", int'(ok), 1);
    repeat (6) press(1, 6);
    chk("amp_back_full", int'(bus.A_idx), 7);

    // back to saw, phase step mid-ramp
    press(0, 6);
    press(0, 6);
    press(2, 6);
    chk("phase_idx", int'(bus.P_idx), 1);

    // frequency steps and wrap
    repeat (3) press(3, 6);
    @(negedge clk); w1 = int'(bus.wave_out);
    @(negedge clk); w2 = int'(bus.wave_out);
    chk("saw_step_f3", (w2 - w1) & DMASK, 4);
    repeat (13) press(3, 6);
    chk("f_wrap_idx", int'(bus.F_idx), 0);
    @(negedge clk); w1 = int'(bus.wave_out);
    @(negedge clk); w2 = int'(bus.wave_out);
    chk("saw_step_f0", (w2 - w1) & DMASK, 1);

    // triangle over a full period
    press(0, 6);
    seen_pk = 0; seen_min = 0;
    repeat (4200) begin
      @(negedge clk);
      if (bus.wave_out == 12'hFFE) seen_pk = 1;
      if (bus.wave_out == 12'h000) seen_min = 1;
    end
    chk("tri_peak_seen", int'(seen_pk), 1);
    chk("tri_min_seen", int'(seen_min), 1);

    // noise
    press(0, 6);
    press(0, 6);
    changes = 0;
    @(negedge clk); w1 = int'(bus.wave_out);
    repeat (50) begin
      @(negedge clk);
      if (int'(bus.wave_out) != w1) changes++;
      w1 = int'(bus.wave_out);
    end
    chk("noise_active", int'(changes > 40), 1);

    // random overlapping key activity, including bounces shorter than DB_CYC
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          keys[k] = 1'($urandom_range(0, 1));
          hold[k] = int'($urandom_range(1, 9));
        end else begin
          hold[k]--;
        end
      end
    end
    keys = '0;
    repeat (12) @(negedge clk);

    // one-cycle reset mid-run
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_wave", int'(bus.wave_out), 'h800);
    chk("midreset_W_idx", int'(bus.W_idx), 0);
    chk("midreset_A_idx", int'(bus.A_idx), 7);
    chk("midreset_F_idx", int'(bus.F_idx), 0);
    chk("midreset_P_idx", int'(bus.P_idx), 0);
    chk("midreset_ps", int'(bus.period_start), 0);
    repeat (300) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_wave_generator.md
Name: dds_wave_generator

Overview:
- Parametrised direct-digital-synthesis waveform core; next generation of the push-button signal generator.
- Replaces fixed-step control with debounced button events, a phase accumulator, phase offset, four waveform modes (including LFSR noise) and linear amplitude scaling.
- Sits under the board top, which inverts the active-low keys and drives the 7-segment decoders from the index outputs.

Parameters:
- DATA_W, 12, output sample width (8..16)
- ACC_W, 24, phase accumulator width (ACC_W >= DATA_W)
- FREQ_SHIFT, 10, frequency tuning word = (F_idx+1) << FREQ_SHIFT
- F_STEPS, 16, number of frequency settings (power of two)
- A_BITS, 3, amplitude index width; scale = (A_idx+1)/2^A_BITS
- P_BITS, 3, phase index width; offset step = 1/2^P_BITS cycle
- DB_CYC, 1000000, debounce stability count in clk cycles

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- W_ctrl  in  1  wave-select key, active-high, asynchronous
- A_ctrl  in  1  amplitude key, active-high, asynchronous
- P_ctrl  in  1  phase key, active-high, asynchronous
- F_ctrl  in  1  frequency key, active-high, asynchronous
- wave_out  out  DATA_W  offset-binary sample
- period_start  out  1  one-cycle pulse aligned with the first sample of each period
- W_idx  out  2  current waveform (0 saw, 1 triangle, 2 square, 3 noise)
- A_idx  out  A_BITS  amplitude index
- F_idx  out  log2(F_STEPS)  frequency index
- P_idx  out  P_BITS  phase-offset index

Behaviour:
- Reset (rst_n low at a clk edge):
  - All registers cleared.
  - W_idx=0, A_idx=all ones, F_idx=0, P_idx=0.
  - Accumulator=0, LFSR=16'hACE1, wave_out=2^(DATA_W-1), period_start=0.
  - Reset mid-operation aborts any debounce in progress.
- Input path: each key passes through a 2-flop synchroniser, then a per-key debouncer.
  - Debounced level toggles only after the synchronised level differs from it for DB_CYC consecutive cycles.
  - Any agreeing cycle clears that key's counter.
- Press event: one-cycle pulse on debounced 0->1. Release produces no event.
- Index updates on press event:
  - W_idx, F_idx and P_idx increment, modulo their range.
  - A_idx increments, wrapping all-ones->0.
  - Simultaneous events on different keys all apply in the same cycle.
- Accumulator:
  - acc <= acc + ((F_idx+1) << FREQ_SHIFT) mod 2^ACC_W every cycle.
  - Frequency, phase and waveform changes never reset acc (phase-continuous).
- Wrap flag: carry out of the add, delayed to align with wave_out.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle. Noise sample = upper DATA_W bits.
- Phase: ph = acc[ACC_W-1 -: DATA_W] + (P_idx << (DATA_W-P_BITS)), mod 2^DATA_W.
- Stage 1 (registered raw sample):
  - saw: raw = ph.
  - triangle: raw = ph MSB ? ~(ph<<1) : (ph<<1), truncated to DATA_W.
  - square: raw = ph MSB ? 0 : 2^DATA_W-1.
  - noise: raw = LFSR bits.
- Stage 2 (registered output):
  - s = raw - 2^(DATA_W-1), signed.
  - wave_out = ((s*(A_idx+1)) >>> A_BITS) + 2^(DATA_W-1).
  - Arithmetic shift; full precision through the multiply.
  - A_idx all ones yields raw exactly.
- Latency: acc value in cycle n reaches wave_out in cycle n+2. An index change affects wave_out 2 cycles after the event.

Test Plan:
(Bench parameters: DATA_W=12, ACC_W=16, FREQ_SHIFT=4, F_STEPS=16, A_BITS=3, P_BITS=3, DB_CYC=4.)
- Reset check: hold rst_n low 5 cycles -> wave_out=0x800, W/A/F/P_idx=0/7/0/0. Release -> wave_out 0x000,0x001,0x002,... one step per cycle; period_start pulses every 4096 cycles.
- Debounce: 3-cycle W_ctrl glitch -> W_idx stays 0. Hold W_ctrl 20 cycles -> W_idx=1 exactly once, updating 7 cycles after the rising edge (2 sync + 4 stable + 1). Release produces no change.
- Amplitude: W_idx=2 (square), one A press (7->0) -> high level 0x8FF, low level 0x700. Second press (A_idx=1) -> 0x9FF/0x600.
- Phase: saw mode, one P press mid-ramp -> wave_out jumps +0x200 mod 0x1000 two cycles later, then continues ramping by 1 per cycle without an accumulator reset.
- Frequency wrap: 3 F presses -> step 4 per cycle, period_start every 1024 cycles. 13 further presses -> F_idx=0, step back to 1.
- Triangle/noise and mid-run reset: W_idx=1 -> peak 0xFFE near ph=0x7FF, minimum 0x000/0x001 at the ends. W_idx=3 -> output changes every cycle. Assert rst_n low for one cycle mid-run -> all outputs return to their reset values on the next edge.
